dsk_dma_reader: RTL and testbench

- Requester side of the extra-slot floppy image read path.
- Takes a (start offset, word count) job from floppy track logic and drives the image-relative read address.
- Captures one 16-bit word per granted RAM slot into a small FIFO and streams the bytes, high byte first, to the IWM emulation over a valid/ready handshake.
- One instance per drive: internal and external. The controller adds the image base address.

---
 rtl/dsk_pkg.sv | 12 +
 rtl/dsk_word_fifo.sv | 71 +++++++
 rtl/dsk_dma_reader.sv | 123 ++++++++++++
 tb/tb_dsk_dma_reader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dsk_pkg.sv
// Shared types and widths for the floppy image DMA reader.
package dsk_pkg;
   localparam int WORD_W        = 16;
   localparam int ADDR_W        = 22;
   localparam int LEN_W_DEFAULT = 13;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_t;
endpackage

// File: rtl/dsk_word_fifo.sv
// Small show-ahead word FIFO: head word is visible on dout whenever not empty.
module dsk_word_fifo
   import dsk_pkg::*;
#(
   parameter int FIFO_AW = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic              flush,
   input  logic [WORD_W-1:0] din,
   output logic [WORD_W-1:0] dout,
   output logic              full,
   output logic              empty,
   output logic [FIFO_AW:0]  level
);
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW-1:0] PTR_ONE   = (FIFO_AW)'(1);
   localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
   localparam logic [FIFO_AW:0]   CNT_DEPTH = (FIFO_AW+1)'(DEPTH);

   logic [WORD_W-1:0]  mem_q [DEPTH];
   logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]   count_q, count_d;
   logic               push_ok, pop_ok;

   assign full    = (count_q == CNT_DEPTH);
   assign empty   = (count_q == '0);
   assign level   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   // A flush wins over any same-cycle push or pop.
   assign push_ok = push && !full && !flush;
   assign pop_ok  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/dsk_dma_reader.sv
// Floppy image read requester: fetches a run of words on granted RAM slots
// and streams them out as bytes, high byte first.
module dsk_dma_reader
   import dsk_pkg::*;
#(
   parameter int FIFO_AW = 2,
   parameter int LEN_W   = LEN_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] startAddr,
   input  logic [LEN_W-1:0]  wordCount,
   output logic [ADDR_W-1:0] dskReadAddr,
   input  logic              dskReadAck,
   input  logic              memoryLatch,
   input  logic [WORD_W-1:0] memDataIn,
   output logic              byteValid,
   output logic [7:0]        byteData,
   input  logic              byteReady,
   output logic              busy,
   output logic              done
);
   localparam logic [ADDR_W-1:0] ADDR_LSB  = (ADDR_W)'(1);
   localparam logic [ADDR_W-1:0] ADDR_TWO  = (ADDR_W)'(2);
   localparam logic [LEN_W-1:0]  LEN_ONE   = (LEN_W)'(1);
   localparam logic [FIFO_AW:0]  LEVEL_ONE = (FIFO_AW+1)'(1);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LEN_W-1:0]   remaining_q, remaining_d;
   logic               phase_q, phase_d;   // 0 = high byte shown, 1 = low byte
   logic               done_q, done_d;

   logic               fifo_push, fifo_pop;
   logic [WORD_W-1:0]  fifo_dout;
   logic               fifo_full, fifo_empty;
   logic [FIFO_AW:0]   fifo_level;
   logic               slot_taken, byte_fire, last_byte;

   // A full FIFO skips the slot, leaving the address put so the word is re-read.
   assign slot_taken = (state_q == FETCH) && dskReadAck && memoryLatch && !fifo_full;
   assign byte_fire  = !fifo_empty && byteReady;
   assign fifo_pop   = byte_fire && phase_q;
   assign fifo_push  = slot_taken && !abort;
   assign last_byte  = fifo_pop && (fifo_level == LEVEL_ONE);

   dsk_word_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .flush (abort),
      .din   (memDataIn),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      phase_d     = phase_q;
      done_d      = 1'b0;
      if (abort) begin
         state_d = IDLE;
         phase_d = 1'b0;
      end else begin
         if (byte_fire) phase_d = !phase_q;
         case (state_q)
            IDLE: begin
               if (start) begin
                  addr_d      = startAddr & ~ADDR_LSB;
                  remaining_d = wordCount;
                  if (wordCount == '0) done_d  = 1'b1;
                  else                 state_d = FETCH;
               end
            end
            FETCH: begin
               if (slot_taken) begin
                  addr_d      = addr_q + ADDR_TWO;
                  remaining_d = remaining_q - LEN_ONE;
                  if (remaining_q == LEN_ONE) state_d = DRAIN;
               end
            end
            DRAIN: begin
               if (last_byte) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         remaining_q <= '0;
         phase_q     <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         remaining_q <= remaining_d;
         phase_q     <= phase_d;
         done_q      <= done_d;
      end
   end

   assign dskReadAddr = addr_q;
   assign byteValid   = !fifo_empty;
   assign byteData    = fifo_empty ? 8'h00 : (phase_q ? fifo_dout[7:0] : fifo_dout[15:8]);
   assign busy        = (state_q != IDLE);
   assign done        = done_q;
endmodule

// File: tb/tb_dsk_dma_reader.sv
// Scoreboard bench for dsk_dma_reader: expected bytes are queued with each job
// and a monitor compares every accepted byte in order.
module tb_dsk_dma_reader;
   logic        clk = 1'b0;
   logic        reset, start, abort;
   logic [21:0] startAddr, dskReadAddr;
   logic [12:0] wordCount;
   logic        dskReadAck, memoryLatch;
   logic [15:0] memDataIn;
   logic        byteValid, byteReady, busy, done;
   logic [7:0]  byteData;

   logic [7:0]  exp_q[$];
   logic [7:0]  exp_byte;
   logic [15:0] ram [logic [21:0]];
   int          checks = 0;
   int          passed = 0;
   int          done_cnt = 0;
   int          done_before;

   always #5 clk = ~clk;

   dsk_dma_reader #(.FIFO_AW(2), .LEN_W(13)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .startAddr   (startAddr),
      .wordCount   (wordCount),
      .dskReadAddr (dskReadAddr),
      .dskReadAck  (dskReadAck),
      .memoryLatch (memoryLatch),
      .memDataIn   (memDataIn),
      .byteValid   (byteValid),
      .byteData    (byteData),
      .byteReady   (byteReady),
      .busy        (busy),
      .done        (done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h required %0h", name, act, exp);
   endtask

   function automatic logic [15:0] ram_rd(input logic [21:0] a);
      return ram.exists(a) ? ram[a] : 16'hDEAD;
   endfunction

   task automatic push_word(input logic [15:0] w);
      exp_q.push_back(w[15:8]);
      exp_q.push_back(w[7:0]);
   endtask

   // Monitor: one comparison per accepted byte.
   always @(negedge clk) begin
      if (!reset && byteValid && byteReady) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL extra_byte: got %02h required none", byteData);
         end else begin
            exp_byte = exp_q.pop_front();
            check("byte", {24'd0, byteData}, {24'd0, exp_byte});
            $display("byte accepted %02h (expected %02h)", byteData, exp_byte);
         end
      end
      if (done) done_cnt++;
   end

   task automatic start_job(input logic [21:0] a, input logic [12:0] n);
      @(posedge clk); #1;
      startAddr = a;
      wordCount = n;
      start     = 1'b1;
      @(posedge clk); #1;
      start     = 1'b0;
   endtask

   // One 4-clk granted bus cycle, 64 clk after the previous call.
   task automatic grant(input logic [21:0] exp_addr, input bit do_abort);
      repeat (60) @(posedge clk);
      #1;
      check("grant_addr", {10'd0, dskReadAddr}, {10'd0, exp_addr});
      dskReadAck = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      check("addr_stable", {10'd0, dskReadAddr}, {10'd0, exp_addr});
      memoryLatch = 1'b1;
      memDataIn   = ram_rd(dskReadAddr);
      abort       = do_abort;
      @(posedge clk); #1;
      dskReadAck  = 1'b0;
      memoryLatch = 1'b0;
      abort       = 1'b0;
      $display("grant at %06h abort=%0d", exp_addr, do_abort);
   endtask

   task automatic wait_done(input string name);
      bit seen = 0;
      for (int k = 0; k < 300; k++) begin
         @(posedge clk); #1;
         if (done) begin seen = 1; break; end
      end
      check(name, {31'd0, seen}, 32'd1);
      check("busy_after_done", {31'd0, busy}, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      check("done_count", done_cnt - done_before, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      startAddr = '0; wordCount = '0;
      dskReadAck = 1'b0; memoryLatch = 1'b0; memDataIn = '0;
      byteReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_addr",  {10'd0, dskReadAddr}, 32'd0);
      check("rst_valid", {31'd0, byteValid}, 32'd0);
      check("rst_data",  {24'd0, byteData}, 32'd0);
      check("rst_busy",  {31'd0, busy}, 32'd0);
      check("rst_done",  {31'd0, done}, 32'd0);
      reset = 1'b0;

      // Basic three-word job
      ram[22'h000400] = 16'h1234;
      ram[22'h000402] = 16'h5678;
      ram[22'h000404] = 16'h9ABC;
      push_word(16'h1234); push_word(16'h5678); push_word(16'h9ABC);
      done_before = done_cnt;
      start_job(22'h000400, 13'd3);
      check("basic_busy", {31'd0, busy}, 32'd1);
      grant(22'h000400, 0);
      grant(22'h000402, 0);
      grant(22'h000404, 0);
      check("basic_end_addr", {10'd0, dskReadAddr}, 32'h406);
      wait_done("basic_done");

      // Backpressure: FIFO fills, extra grants skipped
      for (int i = 0; i < 6; i++) ram[22'h001000 + 22'(2*i)] = {8'(2*i+1), 8'(2*i+2)};
      push_word(16'h0102); push_word(16'h0304); push_word(16'h0506);
      push_word(16'h0708); push_word(16'h090A); push_word(16'h0B0C);
      byteReady = 1'b0;
      done_before = done_cnt;
      start_job(22'h001000, 13'd6);
      grant(22'h001000, 0);
      grant(22'h001002, 0);
      grant(22'h001004, 0);
      grant(22'h001006, 0);
      grant(22'h001008, 0);
      grant(22'h001008, 0);
      check("bp_addr_held", {10'd0, dskReadAddr}, 32'h1008);
      check("bp_valid", {31'd0, byteValid}, 32'd1);
      check("bp_head", {24'd0, byteData}, 32'h01);
      byteReady = 1'b1;
      grant(22'h001008, 0);
      grant(22'h00100A, 0);
      wait_done("bp_done");

      // Odd start address and 22-bit wrap
      ram[22'h3FFFFE] = 16'hCAFE;
      ram[22'h000000] = 16'hBEEF;
      push_word(16'hCAFE); push_word(16'hBEEF);
      done_before = done_cnt;
      start_job(22'h3FFFFF, 13'd2);
      grant(22'h3FFFFE, 0);
      grant(22'h000000, 0);
      check("wrap_end_addr", {10'd0, dskReadAddr}, 32'h2);
      wait_done("wrap_done");

      // Zero length
      done_before = done_cnt;
      start_job(22'h005000, 13'd0);
      check("zero_done_pulse", {31'd0, done}, 32'd1);
      check("zero_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      check("zero_done_low", {31'd0, done}, 32'd0);
      grant(22'h005000, 0);
      check("zero_no_push", {31'd0, byteValid}, 32'd0);
      check("zero_done_count", done_cnt - done_before, 32'd1);

      // Abort on the latch clk of the second grant
      ram[22'h003000] = 16'h0A0B;
      ram[22'h003002] = 16'h0C0D;
      push_word(16'h0A0B);
      done_before = done_cnt;
      start_job(22'h003000, 13'd5);
      grant(22'h003000, 0);
      grant(22'h003002, 1);
      check("abort_valid", {31'd0, byteValid}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", done_cnt - done_before, 32'd0);
      ram[22'h000800] = 16'h55AA;
      push_word(16'h55AA);
      start_job(22'h000800, 13'd1);
      grant(22'h000800, 0);
      wait_done("after_abort_done");

      // Start while busy is ignored
      ram[22'h000600] = 16'hA1B2;
      ram[22'h000602] = 16'hC3D4;
      ram[22'h002000] = 16'hEEEE;
      push_word(16'hA1B2); push_word(16'hC3D4);
      done_before = done_cnt;
      start_job(22'h000600, 13'd2);
      grant(22'h000600, 0);
      start_job(22'h002000, 13'd5);
      grant(22'h000602, 0);
      wait_done("busy_start_done");
      check("busy_start_end_addr", {10'd0, dskReadAddr}, 32'h604);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
